// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl
// Applies a requested video mode to a downstream timing generator. A mode
// change waits for the next vblank rising edge, or for a timeout if no edge
// arrives. It then loads the new timing fields and holds the timing generator
// in reset for HOLD_CYC cycles before reporting completion.
//
// Ports
//   video_clock          : single clock, rising edge
//   reset                : asynchronous active-low reset
//   cfg_valid/cfg_mode   : mode-change request (valid/ready handshake)
//   cfg_ready            : high while idle and able to accept a request
//   cfg_done/cfg_error   : one-cycle completion / rejection pulses
//   vblank               : vertical blank from the timing generator
//   tg_reset             : active-high reset to the timing generator
//   cur_mode             : mode currently applied
//   h_*/v_*              : horizontal/vertical timing fields (10 bits each)
//   hs_neg/vs_neg        : sync polarity, 1 = negative
module video_mode_ctrl #(
  parameter int unsigned HOLD_CYC = 4,
  parameter logic [19:0] TIMEOUT  = 20'd1048575
) (
  input  logic       video_clock,
  input  logic       reset,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_mode,
  output logic       cfg_ready,
  output logic       cfg_done,
  output logic       cfg_error,
  input  logic       vblank,
  output logic       tg_reset,
  output logic [1:0] cur_mode,
  output logic [9:0] h_act,
  output logic [9:0] h_fp,
  output logic [9:0] h_sync,
  output logic [9:0] h_bp,
  output logic [9:0] v_act,
  output logic [9:0] v_fp,
  output logic [9:0] v_sync,
  output logic [9:0] v_bp,
  output logic       hs_neg,
  output logic       vs_neg
);

  typedef enum logic [2:0] {INIT, IDLE, WAIT_VB, HOLD, DONE} state_t;

  typedef struct packed {
    logic [9:0] h_act;
    logic [9:0] h_fp;
    logic [9:0] h_sync;
    logic [9:0] h_bp;
    logic [9:0] v_act;
    logic [9:0] v_fp;
    logic [9:0] v_sync;
    logic [9:0] v_bp;
    logic       hs_neg;
    logic       vs_neg;
  } timing_t;

  localparam logic [19:0] HOLD_LAST = 20'(HOLD_CYC - 1);

  // Mode table. All modes share the horizontal timing. The reserved index
  // falls back to mode0, but it is never loaded because it is rejected.
  function automatic timing_t mode_timing(input logic [1:0] m);
    timing_t t;
    t = '{h_act: 10'd640, h_fp: 10'd16, h_sync: 10'd96, h_bp: 10'd48,
          v_act: 10'd480, v_fp: 10'd10, v_sync: 10'd2,  v_bp: 10'd33,
          hs_neg: 1'b1, vs_neg: 1'b1};
    case (m)
      2'd0: t.v_act = 10'd480;
      2'd1: begin
        t.v_act  = 10'd400;
        t.v_fp   = 10'd12;
        t.v_bp   = 10'd35;
        t.vs_neg = 1'b0;
      end
      2'd2: begin
        t.v_act  = 10'd350;
        t.v_fp   = 10'd37;
        t.v_bp   = 10'd60;
        t.hs_neg = 1'b0;
      end
      default: t.v_act = 10'd480;
    endcase
    return t;
  endfunction

  state_t      state, state_n;
  logic [19:0] cnt, cnt_n;
  logic [1:0]  pend, pend_n;
  logic [1:0]  cur_n;
  timing_t     tm, tm_n;
  logic        vb_prev;
  logic        tg_n, ready_n, done_n, error_n;
  logic        wait_expired;

  // Widen by one bit so a TIMEOUT at the 20-bit maximum cannot wrap.
  assign wait_expired = ({1'b0, cnt} + 21'd1) >= {1'b0, TIMEOUT};

  assign h_act  = tm.h_act;
  assign h_fp   = tm.h_fp;
  assign h_sync = tm.h_sync;
  assign h_bp   = tm.h_bp;
  assign v_act  = tm.v_act;
  assign v_fp   = tm.v_fp;
  assign v_sync = tm.v_sync;
  assign v_bp   = tm.v_bp;
  assign hs_neg = tm.hs_neg;
  assign vs_neg = tm.vs_neg;

  // Next-state and next-output logic. Every output is computed one cycle
  // ahead and then registered.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pend_n  = pend;
    tm_n    = tm;
    cur_n   = cur_mode;
    tg_n    = 1'b0;
    ready_n = 1'b0;
    done_n  = 1'b0;
    error_n = 1'b0;
    case (state)
      INIT: begin
        if (cnt == HOLD_LAST) begin
          state_n = IDLE;
          cnt_n   = 20'd0;
          ready_n = 1'b1;
        end else begin
          cnt_n = cnt + 20'd1;
          tg_n  = 1'b1;
        end
      end
      IDLE: begin
        ready_n = 1'b1;
        if (cfg_valid && cfg_ready) begin
          if (cfg_mode == 2'd3) begin
            error_n = 1'b1;
          end else if (cfg_mode == cur_mode) begin
            done_n = 1'b1;
          end else begin
            pend_n  = cfg_mode;
            state_n = WAIT_VB;
            cnt_n   = 20'd0;
            ready_n = 1'b0;
          end
        end else begin
          cnt_n = 20'd0;
        end
      end
      WAIT_VB: begin
        if ((vblank && !vb_prev) || wait_expired) begin
          state_n = HOLD;
          cnt_n   = 20'd0;
          tm_n    = mode_timing(pend);
          cur_n   = pend;
          tg_n    = 1'b1;
        end else begin
          cnt_n = cnt + 20'd1;
        end
      end
      HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_n = DONE;
          cnt_n   = 20'd0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + 20'd1;
          tg_n  = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        cnt_n   = 20'd0;
        ready_n = 1'b1;
      end
      default: begin
        state_n = INIT;
        cnt_n   = 20'd0;
        tg_n    = 1'b1;
      end
    endcase
  end

  // State and output registers. Reset restores mode0 and holds the timing
  // generator in reset. vb_prev resets high so that a vblank that is already
  // high at reset is not taken as an edge.
  always_ff @(posedge video_clock or negedge reset) begin
    if (!reset) begin
      state     <= INIT;
      cnt       <= 20'd0;
      pend      <= 2'd0;
      tm        <= mode_timing(2'd0);
      cur_mode  <= 2'd0;
      vb_prev   <= 1'b1;
      tg_reset  <= 1'b1;
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pend      <= pend_n;
      tm        <= tm_n;
      cur_mode  <= cur_n;
      vb_prev   <= vblank;
      tg_reset  <= tg_n;
      cfg_ready <= ready_n;
      cfg_done  <= done_n;
      cfg_error <= error_n;
    end
  end

endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb_video_mode_ctrl
// Directed self-checking bench for video_mode_ctrl. Idle-state requests
// (reject, no-op, no request) come from a vector table. Mode switches, the
// vblank timeout and reset during HOLD are exercised as hand-written
// sequences. A second instance with a short TIMEOUT covers the forced switch.
module tb_video_mode_ctrl;

  logic       video_clock;
  logic       reset;
  logic       cfg_valid, cfg_ready, cfg_done, cfg_error, vblank, tg_reset;
  logic [1:0] cfg_mode, cur_mode;
  logic [9:0] h_act, h_fp, h_sync, h_bp, v_act, v_fp, v_sync, v_bp;
  logic       hs_neg, vs_neg;

  logic       t_valid, t_ready, t_done, t_error, t_vblank, t_tg;
  logic [1:0] t_mode, t_cur;
  logic [9:0] t_h_act, t_h_fp, t_h_sync, t_h_bp, t_v_act, t_v_fp, t_v_sync, t_v_bp;
  logic       t_hs_neg, t_vs_neg;

  int tests = 0;
  int fails = 0;

  video_mode_ctrl dut (
    .video_clock(video_clock), .reset(reset),
    .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_ready(cfg_ready),
    .cfg_done(cfg_done), .cfg_error(cfg_error), .vblank(vblank),
    .tg_reset(tg_reset), .cur_mode(cur_mode),
    .h_act(h_act), .h_fp(h_fp), .h_sync(h_sync), .h_bp(h_bp),
    .v_act(v_act), .v_fp(v_fp), .v_sync(v_sync), .v_bp(v_bp),
    .hs_neg(hs_neg), .vs_neg(vs_neg)
  );

  video_mode_ctrl #(.HOLD_CYC(4), .TIMEOUT(20'd50)) dut_to (
    .video_clock(video_clock), .reset(reset),
    .cfg_valid(t_valid), .cfg_mode(t_mode), .cfg_ready(t_ready),
    .cfg_done(t_done), .cfg_error(t_error), .vblank(t_vblank),
    .tg_reset(t_tg), .cur_mode(t_cur),
    .h_act(t_h_act), .h_fp(t_h_fp), .h_sync(t_h_sync), .h_bp(t_h_bp),
    .v_act(t_v_act), .v_fp(t_v_fp), .v_sync(t_v_sync), .v_bp(t_v_bp),
    .hs_neg(t_hs_neg), .vs_neg(t_vs_neg)
  );

  initial video_clock = 1'b0;
  always #5 video_clock = ~video_clock;

  typedef struct {
    logic       valid;
    logic [1:0] mode;
    logic       exp_done;
    logic       exp_error;
    logic [1:0] exp_cur;
    logic [9:0] exp_v_act;
    logic       exp_vs_neg;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge video_clock);
    #1;
  endtask

  // One idle-state vector: the response pulse on the next cycle, then quiet.
  task automatic apply_vec(input int i);
    cfg_valid = tbl[i].valid;
    cfg_mode  = tbl[i].mode;
    step();
    cfg_valid = 1'b0;
    check($sformatf("vec%0d_done", i), 32'(cfg_done), 32'(tbl[i].exp_done));
    check($sformatf("vec%0d_error", i), 32'(cfg_error), 32'(tbl[i].exp_error));
    check($sformatf("vec%0d_ready", i), 32'(cfg_ready), 32'd1);
    check($sformatf("vec%0d_tg", i), 32'(tg_reset), 32'd0);
    check($sformatf("vec%0d_cur", i), 32'(cur_mode), 32'(tbl[i].exp_cur));
    check($sformatf("vec%0d_v_act", i), 32'(v_act), 32'(tbl[i].exp_v_act));
    check($sformatf("vec%0d_vs_neg", i), 32'(vs_neg), 32'(tbl[i].exp_vs_neg));
    step();
    check($sformatf("vec%0d_done_end", i), 32'(cfg_done), 32'd0);
    check($sformatf("vec%0d_error_end", i), 32'(cfg_error), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int tg_cnt;
    int done_cnt;
    int err_cnt;

    tbl[0] = '{1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 10'd480, 1'b1};
    tbl[1] = '{1'b1, 2'd3, 1'b0, 1'b1, 2'd0, 10'd480, 1'b1};
    tbl[2] = '{1'b1, 2'd0, 1'b1, 1'b0, 2'd0, 10'd480, 1'b1};
    tbl[3] = '{1'b0, 2'd3, 1'b0, 1'b0, 2'd0, 10'd480, 1'b1};
    tbl[4] = '{1'b1, 2'd1, 1'b1, 1'b0, 2'd1, 10'd400, 1'b0};
    tbl[5] = '{1'b1, 2'd3, 1'b0, 1'b1, 2'd1, 10'd400, 1'b0};

    reset = 1'b0; cfg_valid = 1'b0; cfg_mode = 2'd0; vblank = 1'b1;
    t_valid = 1'b0; t_mode = 2'd0; t_vblank = 1'b0;

    // Values held while reset is low
    repeat (3) step();
    check("rst_tg", 32'(tg_reset), 32'd1);
    check("rst_ready", 32'(cfg_ready), 32'd0);
    check("rst_done", 32'(cfg_done), 32'd0);
    check("rst_error", 32'(cfg_error), 32'd0);
    check("rst_cur", 32'(cur_mode), 32'd0);
    check("rst_h_act", 32'(h_act), 32'd640);
    check("rst_h_sync", 32'(h_sync), 32'd96);
    check("rst_v_act", 32'(v_act), 32'd480);
    check("rst_v_bp", 32'(v_bp), 32'd33);
    check("rst_hs_neg", 32'(hs_neg), 32'd1);
    check("rst_vs_neg", 32'(vs_neg), 32'd1);

    // tg_reset stays high through INIT, then IDLE
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("init_tg%0d", k), 32'(tg_reset), 32'd1);
      check($sformatf("init_ready%0d", k), 32'(cfg_ready), 32'd0);
    end
    step();
    check("init_tg_end", 32'(tg_reset), 32'd0);
    check("init_ready_end", 32'(cfg_ready), 32'd1);
    check("init_h_act", 32'(h_act), 32'd640);
    check("init_v_act", 32'(v_act), 32'd480);

    // Idle vectors while mode0 is applied
    for (int i = 0; i < 4; i++) apply_vec(i);

    // Forced switch to mode2 with vblank held low (TIMEOUT = 50)
    t_valid = 1'b1; t_mode = 2'd2;
    step();
    t_valid = 1'b0;
    check("to_ready_low", 32'(t_ready), 32'd0);
    repeat (49) step();
    check("to_tg_before", 32'(t_tg), 32'd0);
    check("to_v_act_before", 32'(t_v_act), 32'd480);
    step();
    check("to_tg_hold", 32'(t_tg), 32'd1);
    check("to_v_act", 32'(t_v_act), 32'd350);
    check("to_v_fp", 32'(t_v_fp), 32'd37);
    check("to_hs_neg", 32'(t_hs_neg), 32'd0);
    check("to_vs_neg", 32'(t_vs_neg), 32'd1);
    check("to_cur", 32'(t_cur), 32'd2);

    // Mode1 switch; vblank is high at the request, so no edge yet
    cfg_valid = 1'b1; cfg_mode = 2'd1;
    step();
    cfg_valid = 1'b0;
    check("m1_ready_low", 32'(cfg_ready), 32'd0);
    // A request during WAIT_VB must be dropped
    cfg_valid = 1'b1; cfg_mode = 2'd2;
    step();
    cfg_valid = 1'b0;
    repeat (3) step();
    check("m1_no_edge_cur", 32'(cur_mode), 32'd0);
    check("m1_no_edge_tg", 32'(tg_reset), 32'd0);
    vblank = 1'b0;
    repeat (94) step();
    check("m1_wait_v_act", 32'(v_act), 32'd480);
    vblank = 1'b1;
    step();
    check("m1_hold_v_act", 32'(v_act), 32'd400);
    check("m1_hold_v_bp", 32'(v_bp), 32'd35);
    check("m1_hold_vs_neg", 32'(vs_neg), 32'd0);
    check("m1_hold_hs_neg", 32'(hs_neg), 32'd1);
    check("m1_hold_cur", 32'(cur_mode), 32'd1);
    check("m1_hold_tg", 32'(tg_reset), 32'd1);
    tg_cnt = 1; done_cnt = 0; err_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (tg_reset) tg_cnt++;
      if (cfg_done) done_cnt++;
      if (cfg_error) err_cnt++;
    end
    check("m1_tg_cycles", 32'(tg_cnt), 32'd4);
    check("m1_done_pulses", 32'(done_cnt), 32'd1);
    check("m1_error_pulses", 32'(err_cnt), 32'd0);
    check("m1_ready_after", 32'(cfg_ready), 32'd1);
    check("m1_cur_after", 32'(cur_mode), 32'd1);

    // Idle vectors while mode1 is applied
    for (int i = 4; i < 6; i++) apply_vec(i);

    // Switch back to mode0
    vblank = 1'b0;
    cfg_valid = 1'b1; cfg_mode = 2'd0;
    step();
    cfg_valid = 1'b0;
    step();
    vblank = 1'b1;
    step();
    check("m0_cur", 32'(cur_mode), 32'd0);
    check("m0_v_act", 32'(v_act), 32'd480);
    repeat (6) step();
    check("m0_ready", 32'(cfg_ready), 32'd1);

    // Reset in the middle of HOLD for a mode1 switch
    vblank = 1'b0;
    cfg_valid = 1'b1; cfg_mode = 2'd1;
    step();
    cfg_valid = 1'b0;
    step();
    vblank = 1'b1;
    step();
    check("ab_hold_v_act", 32'(v_act), 32'd400);
    step();
    #2;
    reset = 1'b0;
    #1;
    check("ab_v_act", 32'(v_act), 32'd480);
    check("ab_vs_neg", 32'(vs_neg), 32'd1);
    check("ab_cur", 32'(cur_mode), 32'd0);
    check("ab_tg", 32'(tg_reset), 32'd1);
    check("ab_ready", 32'(cfg_ready), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (cfg_done) done_cnt++;
    end
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      if (cfg_done) done_cnt++;
    end
    check("ab_no_done", 32'(done_cnt), 32'd0);
    check("ab_ready_after", 32'(cfg_ready), 32'd1);
    check("ab_cur_after", 32'(cur_mode), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
